if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline: owns the program counter, drives the instruction-memory address, selects the next PC from the ID-stage redirect, and holds the IF/ID pipeline register. It consumes the `IFIDop` command from the forwarding/stall unit, together with the ID-stage `ID_PCSrc` / `ID_comp_true` decision. It produces the instruction, PC+4 and valid bit seen by the ID stage.

---
 rtl/if_stage_if.sv | 8 +
 rtl/if_stage.sv | 131 +++++++++++++
 tb/tb_if_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory bus between the fetch stage and imem
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS IF stage: PC, next-PC select, IF/ID register.
// Optional performance counters enabled by macro IF_PERF_CNT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  IFIDop,
  input  logic [1:0]  ID_PCSrc,
  input  logic        ID_comp_true,
  input  logic [31:0] ID_BranchTarget,
  input  logic [31:0] ID_JumpTarget,
  input  logic [31:0] ID_JrTarget,
  if_stage_if.master  imem,
  output logic [31:0] PC,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCplus4,
  output logic        IFID_valid,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
);

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_FLUSH = 2'd1;

  localparam logic [1:0] SRC_BRANCH = 2'd1;
  localparam logic [1:0] SRC_JUMP   = 2'd2;
  localparam logic [1:0] SRC_JR     = 2'd3;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        hold;

  // Ops 2 and 3 both mean hold, so bit 1 alone identifies a hold.
  assign hold     = IFIDop[1];
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    target  = pc_plus4;

    if ((ID_PCSrc == SRC_BRANCH) && ID_comp_true) begin
      target = ID_BranchTarget;
    end else if (ID_PCSrc == SRC_JUMP) begin
      target = ID_JumpTarget;
    end else if (ID_PCSrc == SRC_JR) begin
      target = ID_JrTarget;
    end

    if (!hold) begin
      pc_d   = {target[31:2], 2'b00};
      pcp4_d = pc_plus4;
      if (IFIDop == OP_LOAD) begin
        instr_d = imem.imem_rdata;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcp4_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign imem.imem_addr   = pc_q;
  assign PC               = pc_q;
  assign IFID_Instruction = instr_q;
  assign IFID_PCplus4     = pcp4_q;
  assign IFID_valid       = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hold) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else if (IFIDop == OP_FLUSH) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_fetch = fetch_cnt_q;
  assign perf_stall = stall_cnt_q;
  assign perf_flush = flush_cnt_q;
`else
  assign perf_fetch = 32'h0;
  assign perf_stall = 32'h0;
  assign perf_flush = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed bench for if_stage with a spec-level reference model
module tb_if_stage;
  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  IFIDop;
  logic [1:0]  ID_PCSrc;
  logic        ID_comp_true;
  logic [31:0] ID_BranchTarget, ID_JumpTarget, ID_JrTarget;
  logic [31:0] PC, IFID_Instruction, IFID_PCplus4;
  logic        IFID_valid;
  logic [31:0] perf_fetch, perf_stall, perf_flush;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  if_stage_if bus ();

  if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset), .IFIDop(IFIDop), .ID_PCSrc(ID_PCSrc),
    .ID_comp_true(ID_comp_true), .ID_BranchTarget(ID_BranchTarget),
    .ID_JumpTarget(ID_JumpTarget), .ID_JrTarget(ID_JrTarget), .imem(bus.master),
    .PC(PC), .IFID_Instruction(IFID_Instruction), .IFID_PCplus4(IFID_PCplus4),
    .IFID_valid(IFID_valid), .perf_fetch(perf_fetch), .perf_stall(perf_stall),
    .perf_flush(perf_flush)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word derived from each address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h8C00_0001;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  // Reference model: architectural state updated from the rules at each edge.
  logic [31:0] m_pc, m_instr, m_pcp4, m_fetch, m_stall, m_flush;
  logic        m_valid;

  always @(posedge clk) begin
    logic [31:0] nxt;
    if (reset) begin
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_pcp4 = 0; m_valid = 0;
      m_fetch = 0; m_stall = 0; m_flush = 0;
    end else if (IFIDop >= 2) begin
      m_stall = m_stall + 1;
    end else begin
      if (ID_PCSrc == 1 && ID_comp_true) nxt = ID_BranchTarget;
      else if (ID_PCSrc == 2)            nxt = ID_JumpTarget;
      else if (ID_PCSrc == 3)            nxt = ID_JrTarget;
      else                               nxt = m_pc + 4;
      nxt = nxt & 32'hFFFF_FFFC;
      m_pcp4 = m_pc + 4;
      if (IFIDop == 0) begin
        m_instr = mem_word(m_pc); m_valid = 1; m_fetch = m_fetch + 1;
      end else begin
        m_instr = NOP_INSTR; m_valid = 0; m_flush = m_flush + 1;
      end
      m_pc = nxt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_pc", PC, m_pc);
      chk("model_imem_addr", bus.imem_addr, m_pc);
      chk("model_instr", IFID_Instruction, m_instr);
      chk("model_pcplus4", IFID_PCplus4, m_pcp4);
      chk("model_valid", {31'b0, IFID_valid}, {31'b0, m_valid});
`ifdef IF_PERF_CNT_EN
      chk("model_perf_fetch", perf_fetch, m_fetch);
      chk("model_perf_stall", perf_stall, m_stall);
      chk("model_perf_flush", perf_flush, m_flush);
`else
      chk("perf_fetch_tied", perf_fetch, 32'h0);
      chk("perf_stall_tied", perf_stall, 32'h0);
      chk("perf_flush_tied", perf_flush, 32'h0);
`endif
    end
  end

  task automatic step(input logic [1:0] op, input logic [1:0] src, input logic comp);
    IFIDop = op; ID_PCSrc = src; ID_comp_true = comp;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_perf(input string name, input int f, input int s, input int fl);
`ifdef IF_PERF_CNT_EN
    chk({name, "_fetch"}, perf_fetch, f);
    chk({name, "_stall"}, perf_stall, s);
    chk({name, "_flush"}, perf_flush, fl);
`else
    chk({name, "_fetch"}, perf_fetch, 32'h0);
    chk({name, "_stall"}, perf_stall, 32'h0);
    chk({name, "_flush"}, perf_flush, 32'h0);
`endif
  endtask

  logic [31:0] held_pc, held_instr;

  initial begin
    reset = 1; IFIDop = 0; ID_PCSrc = 0; ID_comp_true = 0;
    ID_BranchTarget = 0; ID_JumpTarget = 0; ID_JrTarget = 0;
    step(0, 0, 0);
    cmp_en = 1;
    step(0, 0, 0);
    chk("reset_pc", PC, 32'h0040_0000);
    chk("reset_valid", {31'b0, IFID_valid}, 32'h0);
    chk("reset_pcplus4", IFID_PCplus4, 32'h0);
    chk("reset_instr", IFID_Instruction, NOP_INSTR);
    chk_perf("reset_perf", 0, 0, 0);

    reset = 0;
    step(0, 0, 0);
    chk("run1_pc", PC, 32'h0040_0004);
    chk("run1_valid", {31'b0, IFID_valid}, 32'h1);
    chk("run1_pcplus4", IFID_PCplus4, 32'h0040_0004);
    chk("run1_instr", IFID_Instruction, mem_word(32'h0040_0000));
    step(0, 0, 0);
    chk("run2_pc", bus.imem_addr, 32'h0040_0008);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("pre_branch_pc", PC, 32'h0040_0010);

    ID_BranchTarget = 32'h0040_0100;
    step(1, 1, 1);
    chk("taken_instr", IFID_Instruction, NOP_INSTR);
    chk("taken_valid", {31'b0, IFID_valid}, 32'h0);
    chk("taken_pc", PC, 32'h0040_0100);
    step(0, 0, 0);
    chk("target_instr", IFID_Instruction, mem_word(32'h0040_0100));
    chk("target_valid", {31'b0, IFID_valid}, 32'h1);

    step(0, 1, 0);
    chk("nottaken_pc", PC, 32'h0040_0108);
    chk("nottaken_instr", IFID_Instruction, mem_word(32'h0040_0104));

    ID_JumpTarget = 32'h0040_0200;
    held_pc = PC; held_instr = IFID_Instruction;
    for (int i = 0; i < 3; i++) begin
      step(2, 2, 0);
      chk("hold_pc", PC, held_pc);
      chk("hold_instr", IFID_Instruction, held_instr);
    end
    step(1, 2, 0);
    chk("after_hold_pc", PC, 32'h0040_0200);
    chk("after_hold_valid", {31'b0, IFID_valid}, 32'h0);

    ID_JrTarget = 32'h0040_0203;
    step(1, 3, 0);
    chk("jr_align_pc", PC, 32'h0040_0200);

    ID_JrTarget = 32'hFFFF_FFFF;
    step(1, 3, 0);
    chk("jr_top_pc", PC, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("wrap_pc", PC, 32'h0000_0000);
    chk("wrap_pcplus4", IFID_PCplus4, 32'h0000_0000);
    chk("wrap_instr", IFID_Instruction, mem_word(32'hFFFF_FFFC));

    step(3, 0, 0);
    reset = 1;
    step(2, 2, 0);
    chk("hold_reset_pc", PC, 32'h0040_0000);
    chk("hold_reset_valid", {31'b0, IFID_valid}, 32'h0);
    chk_perf("hold_reset_perf", 0, 0, 0);

    reset = 0;
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    step(2, 0, 0);
    step(3, 0, 0);
    step(1, 0, 0);
    chk_perf("count_perf", 5, 2, 1);
    chk("count_pc", PC, 32'h0040_0018);

    IFIDop = 1;
    reset = 1;
    step(1, 2, 0);
    chk("flush_reset_pc", PC, 32'h0040_0000);
    chk_perf("flush_reset_perf", 0, 0, 0);
    reset = 0;
    step(0, 0, 0);

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
